// File: rtl/id_hazard_ctrl.sv
// Decode-stage hazard and stall controller.
// Combines load-use detection against the EX (and optionally MEM) load
// stages, a post-issue AMO serialisation window and EX redirect flushing.
// Produces the IF/ID hold, the ID/EX bubble and the front-end flush, and
// keeps a saturating count of stalled cycles.
module id_hazard_ctrl #(
    parameter int NUM_SRC          = 2,
    parameter int REG_AW           = 5,
    parameter int LOAD_USE_DEPTH   = 1,
    parameter int AMO_STALL_CYCLES = 3,
    parameter int CNT_WIDTH        = 16
) (
    input  logic                      clk,
    input  logic                      arst_n,
    input  logic                      id_valid_in,
    input  logic [NUM_SRC*REG_AW-1:0] id_rs_in,
    input  logic [NUM_SRC-1:0]        id_rs_used_in,
    input  logic                      id_is_amo_in,
    input  logic                      ex_valid_in,
    input  logic [REG_AW-1:0]         ex_rd_in,
    input  logic                      ex_is_load_in,
    input  logic                      mem_valid_in,
    input  logic [REG_AW-1:0]         mem_rd_in,
    input  logic                      mem_is_load_in,
    input  logic                      redirect_in,
    input  logic                      clr_cnt_in,
    output logic                      stall_out,
    output logic                      bubble_out,
    output logic                      flush_out,
    output logic                      amo_busy_out,
    output logic [CNT_WIDTH-1:0]      stall_cnt_out
);

    // AMO window counter width; a zero-cycle window still needs one bit.
    localparam int AMO_CW = (AMO_STALL_CYCLES > 0) ? $clog2(AMO_STALL_CYCLES + 1) : 1;

    localparam logic [AMO_CW-1:0]    AMO_LOAD  = AMO_CW'(AMO_STALL_CYCLES);
    localparam logic [AMO_CW-1:0]    AMO_ONE   = AMO_CW'(1);
    localparam logic [AMO_CW-1:0]    AMO_ZERO  = '0;
    localparam logic [REG_AW-1:0]    REG_ZERO  = '0;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_ZERO  = '0;
    // MEM comparison only exists for a two-deep load pipeline.
    localparam logic                 CHECK_MEM = (LOAD_USE_DEPTH == 2) ? 1'b1 : 1'b0;

    // A downstream instruction that will write back load data to rd.
    function automatic logic load_dest_hit(
        input logic              valid,
        input logic              is_load,
        input logic [REG_AW-1:0] rd,
        input logic [REG_AW-1:0] rs
    );
        return valid & is_load & (rd == rs);
    endfunction

    // Saturating increment: the counter parks at all-ones.
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        logic [CNT_WIDTH-1:0] r;
        if (v == CNT_MAX) begin
            r = v;
        end else begin
            r = v + CNT_ONE;
        end
        return r;
    endfunction

    logic [NUM_SRC-1:0]   op_hit_s;
    logic                 hz_ld_s;
    logic                 amo_busy_s;
    logic                 stall_s;
    logic                 amo_issue_s;
    logic [AMO_CW-1:0]    amo_cnt_q;
    logic [AMO_CW-1:0]    amo_cnt_d;
    logic [CNT_WIDTH-1:0] stall_cnt_q;
    logic [CNT_WIDTH-1:0] stall_cnt_d;

    // Per-operand load-use match; x0 and unread operands never match.
    always_comb begin
        op_hit_s = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            op_hit_s[i] = id_rs_used_in[i]
                        & (id_rs_in[i*REG_AW +: REG_AW] != REG_ZERO)
                        & ( load_dest_hit(ex_valid_in, ex_is_load_in, ex_rd_in,
                                          id_rs_in[i*REG_AW +: REG_AW])
                          | (CHECK_MEM
                             & load_dest_hit(mem_valid_in, mem_is_load_in, mem_rd_in,
                                             id_rs_in[i*REG_AW +: REG_AW])));
        end
    end

    // Hazard qualified by a valid decode slot so an idle slot with
    // unknown register fields cannot raise a stall.
    assign hz_ld_s     = id_valid_in & (|op_hit_s);
    assign amo_busy_s  = (amo_cnt_q != AMO_ZERO);
    // Redirect outranks any stall: the decode slot is being flushed anyway.
    assign stall_s     = ~redirect_in & (hz_ld_s | amo_busy_s);
    // The AMO only counts as issued when it really leaves decode.
    assign amo_issue_s = id_valid_in & id_is_amo_in & ~stall_s & ~redirect_in;

    // AMO window next state: load on issue, otherwise run down to zero.
    // A running window is not touched by redirect since the AMO is older.
    always_comb begin
        amo_cnt_d = amo_cnt_q;
        if (amo_issue_s) begin
            amo_cnt_d = AMO_LOAD;
        end else if (amo_cnt_q != AMO_ZERO) begin
            amo_cnt_d = amo_cnt_q - AMO_ONE;
        end else begin
            amo_cnt_d = amo_cnt_q;
        end
    end

    // Stall performance counter next state: clear beats increment.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (clr_cnt_in) begin
            stall_cnt_d = CNT_ZERO;
        end else if (stall_s) begin
            stall_cnt_d = sat_inc(stall_cnt_q);
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // AMO window counter register.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            amo_cnt_q <= AMO_ZERO;
        end else begin
            amo_cnt_q <= amo_cnt_d;
        end
    end

    // Stall performance counter register.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            stall_cnt_q <= CNT_ZERO;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_out     = stall_s;
    assign bubble_out    = redirect_in | stall_s;
    assign flush_out     = redirect_in;
    assign amo_busy_out  = amo_busy_s;
    assign stall_cnt_out = stall_cnt_q;

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Directed bench for id_hazard_ctrl. Two instances share one stimulus bus:
// dut_a uses the default parameters (2 operands, EX-only, 16-bit counter),
// dut_b uses 3 operands, EX+MEM checking and a 4-bit counter.
// Flag vectors are {stall, bubble, flush, amo_busy}.
module tb_id_hazard_ctrl;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        arst_n;
    logic        id_valid;
    logic [14:0] id_rs;
    logic [2:0]  id_used;
    logic        id_is_amo;
    logic        ex_valid;
    logic [4:0]  ex_rd;
    logic        ex_is_load;
    logic        mem_valid;
    logic [4:0]  mem_rd;
    logic        mem_is_load;
    logic        redirect;
    logic        clr_cnt;

    logic        a_stall, a_bubble, a_flush, a_busy;
    logic [15:0] a_cnt;
    logic        b_stall, b_bubble, b_flush, b_busy;
    logic [3:0]  b_cnt;

    wire  [3:0]  a_flags = {a_stall, a_bubble, a_flush, a_busy};
    wire  [3:0]  b_flags = {b_stall, b_bubble, b_flush, b_busy};

    int checks   = 0;
    int failures = 0;

    id_hazard_ctrl dut_a (
        .clk(clk), .arst_n(arst_n),
        .id_valid_in(id_valid), .id_rs_in(id_rs[9:0]), .id_rs_used_in(id_used[1:0]),
        .id_is_amo_in(id_is_amo),
        .ex_valid_in(ex_valid), .ex_rd_in(ex_rd), .ex_is_load_in(ex_is_load),
        .mem_valid_in(mem_valid), .mem_rd_in(mem_rd), .mem_is_load_in(mem_is_load),
        .redirect_in(redirect), .clr_cnt_in(clr_cnt),
        .stall_out(a_stall), .bubble_out(a_bubble), .flush_out(a_flush),
        .amo_busy_out(a_busy), .stall_cnt_out(a_cnt)
    );

    id_hazard_ctrl #(
        .NUM_SRC(3), .REG_AW(5), .LOAD_USE_DEPTH(2), .AMO_STALL_CYCLES(3), .CNT_WIDTH(4)
    ) dut_b (
        .clk(clk), .arst_n(arst_n),
        .id_valid_in(id_valid), .id_rs_in(id_rs), .id_rs_used_in(id_used),
        .id_is_amo_in(id_is_amo),
        .ex_valid_in(ex_valid), .ex_rd_in(ex_rd), .ex_is_load_in(ex_is_load),
        .mem_valid_in(mem_valid), .mem_rd_in(mem_rd), .mem_is_load_in(mem_is_load),
        .redirect_in(redirect), .clr_cnt_in(clr_cnt),
        .stall_out(b_stall), .bubble_out(b_bubble), .flush_out(b_flush),
        .amo_busy_out(b_busy), .stall_cnt_out(b_cnt)
    );

    task automatic clear_inputs();
        id_valid = 1'b0; id_rs = 15'd0; id_used = 3'd0; id_is_amo = 1'b0;
        ex_valid = 1'b0; ex_rd = 5'd0; ex_is_load = 1'b0;
        mem_valid = 1'b0; mem_rd = 5'd0; mem_is_load = 1'b0;
        redirect = 1'b0; clr_cnt = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        arst_n = 1'b0;
        clear_inputs();
        #2;
        checks++;
        if (a_flags !== 4'b0000 || a_cnt !== 16'd0) begin
            failures++;
            $display("FAIL reset_a flags=%b cnt=%0d expected flags=0000 cnt=0", a_flags, a_cnt);
        end
        checks++;
        if (b_flags !== 4'b0000 || b_cnt !== 4'd0) begin
            failures++;
            $display("FAIL reset_b flags=%b cnt=%0d expected flags=0000 cnt=0", b_flags, b_cnt);
        end
        @(posedge clk);
        #1 arst_n = 1'b1;
    endtask

    task automatic test_ex_load_use();
        ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd5;
        id_valid = 1'b1; id_rs = 15'd5; id_used = 3'b001;
        #1;
        checks++;
        if (a_flags !== 4'b1100 || b_flags !== 4'b1100) begin
            failures++;
            $display("FAIL ex_load_use a=%b b=%b expected 1100", a_flags, b_flags);
        end
        tick();
        // Load moves to MEM: only the two-deep instance stalls again.
        ex_valid = 1'b0; ex_is_load = 1'b0; ex_rd = 5'd0;
        mem_valid = 1'b1; mem_is_load = 1'b1; mem_rd = 5'd5;
        #1;
        checks++;
        if (a_flags !== 4'b0000 || b_flags !== 4'b1100) begin
            failures++;
            $display("FAIL ex_then_mem a=%b b=%b expected a=0000 b=1100", a_flags, b_flags);
        end
        tick();
        checks++;
        if (a_cnt !== 16'd1 || b_cnt !== 4'd2) begin
            failures++;
            $display("FAIL cnt_after_load a=%0d b=%0d expected a=1 b=2", a_cnt, b_cnt);
        end
        // x0 never stalls.
        clear_inputs();
        ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd0;
        id_valid = 1'b1; id_rs = 15'd0; id_used = 3'b001;
        #1;
        checks++;
        if (a_flags !== 4'b0000 || b_flags !== 4'b0000) begin
            failures++;
            $display("FAIL x0_no_stall a=%b b=%b expected 0000", a_flags, b_flags);
        end
        tick();
        checks++;
        if (a_cnt !== 16'd1 || b_cnt !== 4'd2) begin
            failures++;
            $display("FAIL cnt_hold a=%0d b=%0d expected a=1 b=2", a_cnt, b_cnt);
        end
        clear_inputs();
    endtask

    task automatic test_mem_load_use();
        mem_valid = 1'b1; mem_is_load = 1'b1; mem_rd = 5'd7;
        id_valid = 1'b1; id_rs = {5'd0, 5'd7, 5'd0}; id_used = 3'b010;
        #1;
        checks++;
        if (a_stall !== 1'b0 || b_stall !== 1'b1) begin
            failures++;
            $display("FAIL mem_rs2 a_stall=%b b_stall=%b expected a=0 b=1", a_stall, b_stall);
        end
        id_used = 3'b000;
        #1;
        checks++;
        if (b_stall !== 1'b0) begin
            failures++;
            $display("FAIL mem_unused b_stall=%b expected 0", b_stall);
        end
        id_rs = {5'd7, 5'd0, 5'd0}; id_used = 3'b100;
        #1;
        checks++;
        if (a_stall !== 1'b0 || b_stall !== 1'b1) begin
            failures++;
            $display("FAIL mem_rs3 a_stall=%b b_stall=%b expected a=0 b=1", a_stall, b_stall);
        end
        // Idle decode slot with unknown register fields stays clean.
        ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd7;
        id_valid = 1'b0; id_rs = 15'bx; id_used = 3'b111;
        #1;
        checks++;
        if (a_flags !== 4'b0000 || b_flags !== 4'b0000) begin
            failures++;
            $display("FAIL idle_no_x a=%b b=%b expected 0000", a_flags, b_flags);
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_amo();
        id_valid = 1'b1; id_is_amo = 1'b1;
        #1;
        checks++;
        if (a_flags !== 4'b0000 || b_flags !== 4'b0000) begin
            failures++;
            $display("FAIL amo_issue a=%b b=%b expected 0000", a_flags, b_flags);
        end
        for (int k = 1; k <= 3; k++) begin
            tick();
            checks++;
            if (a_flags !== 4'b1101 || b_flags !== 4'b1101) begin
                failures++;
                $display("FAIL amo_window_t%0d a=%b b=%b expected 1101", k, a_flags, b_flags);
            end
        end
        tick();
        checks++;
        if (a_flags !== 4'b0000 || b_flags !== 4'b0000) begin
            failures++;
            $display("FAIL amo_window_end a=%b b=%b expected 0000", a_flags, b_flags);
        end
        tick();
        checks++;
        if (a_flags !== 4'b1101 || b_flags !== 4'b1101) begin
            failures++;
            $display("FAIL amo_second a=%b b=%b expected 1101", a_flags, b_flags);
        end
        clear_inputs();
        tick(); tick(); tick();
        checks++;
        if (a_flags !== 4'b0000 || b_flags !== 4'b0000) begin
            failures++;
            $display("FAIL amo_drain a=%b b=%b expected 0000", a_flags, b_flags);
        end
    endtask

    task automatic test_redirect();
        id_valid = 1'b1; id_is_amo = 1'b1; redirect = 1'b1;
        #1;
        checks++;
        if (a_flags !== 4'b0110 || b_flags !== 4'b0110) begin
            failures++;
            $display("FAIL redirect_amo a=%b b=%b expected 0110", a_flags, b_flags);
        end
        tick();
        clear_inputs();
        #1;
        checks++;
        if (a_flags !== 4'b0000 || b_flags !== 4'b0000) begin
            failures++;
            $display("FAIL amo_flushed a=%b b=%b expected 0000", a_flags, b_flags);
        end
        ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd9;
        id_valid = 1'b1; id_rs = 15'd9; id_used = 3'b001; redirect = 1'b1;
        #1;
        checks++;
        if (a_flags !== 4'b0110 || b_flags !== 4'b0110) begin
            failures++;
            $display("FAIL redirect_hazard a=%b b=%b expected 0110", a_flags, b_flags);
        end
        clear_inputs();
        id_valid = 1'b1; id_is_amo = 1'b1;
        tick();
        clear_inputs();
        redirect = 1'b1;
        #1;
        checks++;
        if (a_flags !== 4'b0111 || b_flags !== 4'b0111) begin
            failures++;
            $display("FAIL redirect_busy_t1 a=%b b=%b expected 0111", a_flags, b_flags);
        end
        tick();
        checks++;
        if (a_flags !== 4'b0111 || b_flags !== 4'b0111) begin
            failures++;
            $display("FAIL redirect_busy_t2 a=%b b=%b expected 0111", a_flags, b_flags);
        end
        redirect = 1'b0;
        tick();
        checks++;
        if (a_flags !== 4'b1101 || b_flags !== 4'b1101) begin
            failures++;
            $display("FAIL redirect_busy_t3 a=%b b=%b expected 1101", a_flags, b_flags);
        end
        tick();
        checks++;
        if (a_flags !== 4'b0000 || b_flags !== 4'b0000) begin
            failures++;
            $display("FAIL redirect_busy_t4 a=%b b=%b expected 0000", a_flags, b_flags);
        end
    endtask

    task automatic test_cnt_saturate();
        clear_inputs();
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        checks++;
        if (a_cnt !== 16'd0 || b_cnt !== 4'd0) begin
            failures++;
            $display("FAIL cnt_clear a=%0d b=%0d expected 0", a_cnt, b_cnt);
        end
        ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd3;
        id_valid = 1'b1; id_rs = 15'd3; id_used = 3'b001;
        for (int k = 0; k < 20; k++) tick();
        checks++;
        if (a_cnt !== 16'd20 || b_cnt !== 4'd15) begin
            failures++;
            $display("FAIL cnt_saturate a=%0d b=%0d expected a=20 b=15", a_cnt, b_cnt);
        end
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        checks++;
        if (a_cnt !== 16'd0 || b_cnt !== 4'd0) begin
            failures++;
            $display("FAIL cnt_clear_wins a=%0d b=%0d expected 0", a_cnt, b_cnt);
        end
        tick();
        checks++;
        if (a_cnt !== 16'd1 || b_cnt !== 4'd1) begin
            failures++;
            $display("FAIL cnt_restart a=%0d b=%0d expected 1", a_cnt, b_cnt);
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_reset_mid_amo();
        id_valid = 1'b1; id_is_amo = 1'b1;
        tick();
        clear_inputs();
        tick();
        checks++;
        if (a_busy !== 1'b1 || b_busy !== 1'b1) begin
            failures++;
            $display("FAIL amo_before_reset a=%b b=%b expected 1", a_busy, b_busy);
        end
        #1 arst_n = 1'b0;
        #1;
        checks++;
        if (a_flags !== 4'b0000 || b_flags !== 4'b0000 || a_cnt !== 16'd0 || b_cnt !== 4'd0) begin
            failures++;
            $display("FAIL async_reset a=%b/%0d b=%b/%0d expected 0000/0", a_flags, a_cnt, b_flags, b_cnt);
        end
        #1 arst_n = 1'b1;
        tick(); tick();
        checks++;
        if (a_flags !== 4'b0000 || b_flags !== 4'b0000) begin
            failures++;
            $display("FAIL after_reset a=%b b=%b expected 0000", a_flags, b_flags);
        end
        ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd12;
        id_valid = 1'b1; id_rs = 15'd12; id_used = 3'b001;
        #1;
        checks++;
        if (a_flags !== 4'b1100 || b_flags !== 4'b1100) begin
            failures++;
            $display("FAIL new_hazard a=%b b=%b expected 1100", a_flags, b_flags);
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_ex_load_use();
        test_mem_load_use();
        test_amo();
        test_redirect();
        test_cnt_saturate();
        test_reset_mid_amo();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
